gray_stream_pipe: RTL and testbench
===================================

// Module: gray_stream_pipe
// PURPOSE
//  Streaming, parametrised RGB-to-gray converter for the edge-detection datapath.
//  Accepts one packed RGB pixel per cycle on a valid/ready handshake. Produces one gray pixel per accepted pixel.
//  Four runtime-selectable conversion modes; fixed 3-cycle pipeline with full backpressure support.
//  Counts pixels per frame and flags the last pixel. Sits between the pixel fetch and the edge filter.
// PARAMETERS
//  PIX_W         8    bits per colour channel and per gray output
//  FRAME_PIXELS  64   pixels per frame; o_last marks every FRAME_PIXELS-th output (>=1)
// PORTS
//  clk           in   1         system clock, rising edge
//  rst           in   1         asynchronous, active-high reset
//  i_mode        in   2         conversion mode, sampled with each accepted pixel
//  i_valid       in   1         input pixel valid
//  o_ready       out  1         block can accept a pixel this cycle
//  i_RGB         in   4*PIX_W   {R,G,B,pad}: R=[4W-1:3W], G=[3W-1:2W], B=[2W-1:W], pad ignored
//  o_valid       out  1         o_gray valid
//  i_ready       in   1         downstream accepts o_gray this cycle
//  o_gray        out  PIX_W     gray result
//  o_last        out  1         qualifies o_valid: this pixel is the last of a frame
// BEHAVIOUR
//  Reset: all stage valids=0, o_valid=0, o_gray=0, o_last=0, frame count=0; o_ready=1 after reset.
//   Reset mid-stream discards all in-flight pixels and clears the frame count.
//  Handshake: input accepted when i_valid&o_ready; output consumed when o_valid&i_ready.
//   stall = o_valid & ~i_ready; o_ready = ~stall (combinational).
//   On stall, all stages hold their contents; o_gray and o_last stay stable while o_valid is high.
//   Pipeline bubbles advance normally: an empty stage never blocks.
//  Pipeline: S1 registers R,G,B,mode. S2 computes max, min, sum, lum, and the mode result. S3 is the output register.
//   Latency is exactly 3 cycles from accept to o_valid when not stalled; throughput is 1 pixel/cycle.
//  Modes (all unsigned; intermediates wide enough that nothing overflows):
//   0 LIGHTNESS  gray = (max(R,G,B)+min(R,G,B)) >> 1        (PIX_W+1-bit sum)
//   1 LUMINOSITY gray = (77*R + 150*G + 29*B) >> 8          (PIX_W+8-bit acc)
//   2 AVERAGE    gray = ((R+G+B) * 171) >> 9                (exact defined formula, truncating)
//   3 VALUE      gray = max(R,G,B)
//   Every result truncates to PIX_W bits. No mode can exceed 2^PIX_W-1, so no saturation is needed.
//  Each pixel uses the mode captured with it; changing i_mode between pixels takes effect on the next accepted pixel.
//  Frame counter (range 0..FRAME_PIXELS-1):
//   Increments on each output handshake.
//   o_last=1 when o_valid and count==FRAME_PIXELS-1.
//   On that handshake the count wraps to 0.
//   FRAME_PIXELS=1 makes o_last=1 on every output.
//   Count never changes while stalled.
//  Simultaneous accept and output in one cycle are independent; the pipeline stays full at 1 pixel/cycle.
// TESTING
//  T1 mode0, RGB=(200,100,50), i_ready=1 -> o_gray=125 exactly 3 cycles after accept.
//  T2 same pixel in modes 1/2/3 -> 124 / 116 / 200.
//   Also (255,255,255) in all modes -> 255; (0,0,0) -> 0.
//  T3 back-to-back stream of 10 pixels with mode toggled each pixel, i_ready=1
//   -> 10 outputs on consecutive cycles, each computed with its own mode.
//  T4 hold i_ready=0 for 5 cycles with a full pipeline
//   -> o_ready=0, o_gray/o_last stable, no loss or duplication after release.
//  T5 FRAME_PIXELS=4, stream 9 pixels -> o_last on outputs 4 and 8 only.
//   Random i_ready -> same positions.
//  T6 assert rst with 3 pixels in flight -> o_valid=0 next cycle, count=0.
//   First post-reset frame's o_last is on its 4th output.

Source files
------------

// File: rtl/gray_stream_pipe.sv
// Streaming RGB-to-gray converter: three-stage valid/ready pipeline with four
// runtime-selectable conversion modes and a per-frame last-pixel flag.
module gray_stream_pipe #(
  parameter int PIX_W        = 8,
  parameter int FRAME_PIXELS = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         i_mode,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [4*PIX_W-1:0] i_RGB,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [PIX_W-1:0]   o_gray,
  output logic               o_last
);

  localparam int CNT_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;

  typedef enum logic [1:0] {
    MODE_LIGHTNESS  = 2'd0,
    MODE_LUMINOSITY = 2'd1,
    MODE_AVERAGE    = 2'd2,
    MODE_VALUE      = 2'd3
  } mode_e;

  logic             s1_valid_q, s1_valid_d;
  logic [PIX_W-1:0] s1_r_q, s1_r_d, s1_g_q, s1_g_d, s1_b_q, s1_b_d;
  mode_e            s1_mode_q, s1_mode_d;
  logic             s2_valid_q, s2_valid_d;
  logic [PIX_W-1:0] s2_gray_q, s2_gray_d;
  logic             s3_valid_q, s3_valid_d;
  logic [PIX_W-1:0] s3_gray_q, s3_gray_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic               stall;
  logic               is_last;
  logic [PIX_W-1:0]   px_max, px_min, mode_gray;
  logic [PIX_W:0]     light_sum;
  logic [PIX_W+7:0]   lum_acc;
  logic [PIX_W+1:0]   sum3;
  logic [PIX_W+9:0]   avg_prod;
  logic               unused_pad;

  // The pad channel carries no information.
  assign unused_pad = ^i_RGB[PIX_W-1:0];

  assign stall   = s3_valid_q & ~i_ready;
  assign is_last = (cnt_q == CNT_W'(FRAME_PIXELS - 1));

  // Stage-2 arithmetic, evaluated on the stage-1 registers.
  always_comb begin
    px_max = s1_r_q;
    px_min = s1_r_q;
    if (s1_g_q > px_max) px_max = s1_g_q;
    if (s1_b_q > px_max) px_max = s1_b_q;
    if (s1_g_q < px_min) px_min = s1_g_q;
    if (s1_b_q < px_min) px_min = s1_b_q;

    light_sum = (PIX_W+1)'(px_max) + (PIX_W+1)'(px_min);
    lum_acc   = (PIX_W+8)'(s1_r_q) * (PIX_W+8)'(77)
              + (PIX_W+8)'(s1_g_q) * (PIX_W+8)'(150)
              + (PIX_W+8)'(s1_b_q) * (PIX_W+8)'(29);
    sum3      = (PIX_W+2)'(s1_r_q) + (PIX_W+2)'(s1_g_q) + (PIX_W+2)'(s1_b_q);
    avg_prod  = (PIX_W+10)'(sum3) * (PIX_W+10)'(171);

    unique case (s1_mode_q)
      MODE_LIGHTNESS:  mode_gray = PIX_W'(light_sum >> 1);
      MODE_LUMINOSITY: mode_gray = PIX_W'(lum_acc >> 8);
      MODE_AVERAGE:    mode_gray = PIX_W'(avg_prod >> 9);
      default:         mode_gray = px_max;
    endcase
  end

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block
    // leaves a signal unassigned, which would infer a latch.
    s1_valid_d = s1_valid_q;
    s1_r_d     = s1_r_q;
    s1_g_d     = s1_g_q;
    s1_b_d     = s1_b_q;
    s1_mode_d  = s1_mode_q;
    s2_valid_d = s2_valid_q;
    s2_gray_d  = s2_gray_q;
    s3_valid_d = s3_valid_q;
    s3_gray_d  = s3_gray_q;
    cnt_d      = cnt_q;

    // A stall freezes the whole pipe; otherwise bubbles move like data.
    if (!stall) begin
      s1_valid_d = i_valid;
      if (i_valid) begin
        s1_r_d    = i_RGB[4*PIX_W-1:3*PIX_W];
        s1_g_d    = i_RGB[3*PIX_W-1:2*PIX_W];
        s1_b_d    = i_RGB[2*PIX_W-1:PIX_W];
        s1_mode_d = mode_e'(i_mode);
      end
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) s2_gray_d = mode_gray;
      s3_valid_d = s2_valid_q;
      if (s2_valid_q) s3_gray_d = s2_gray_q;
    end

    if (s3_valid_q && i_ready) cnt_d = is_last ? '0 : cnt_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: data registers are reset too; o_gray must read 0 out of reset.
      s1_valid_q <= 1'b0;
      s1_r_q     <= '0;
      s1_g_q     <= '0;
      s1_b_q     <= '0;
      s1_mode_q  <= MODE_LIGHTNESS;
      s2_valid_q <= 1'b0;
      s2_gray_q  <= '0;
      s3_valid_q <= 1'b0;
      s3_gray_q  <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_r_q     <= s1_r_d;
      s1_g_q     <= s1_g_d;
      s1_b_q     <= s1_b_d;
      s1_mode_q  <= s1_mode_d;
      s2_valid_q <= s2_valid_d;
      s2_gray_q  <= s2_gray_d;
      s3_valid_q <= s3_valid_d;
      s3_gray_q  <= s3_gray_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_ready = ~stall;
  assign o_valid = s3_valid_q;
  assign o_gray  = s3_gray_q;
  assign o_last  = s3_valid_q & is_last;

endmodule

// File: tb/tb_gray_stream_pipe.sv
// Self-checking bench for gray_stream_pipe: directed and random pixels scored
// against an arithmetic reference model and a frame-position model.
module tb_gray_stream_pipe;

  localparam int PIX_W = 8;
  localparam int FP    = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         i_mode;
  logic               i_valid;
  logic               i_ready;
  logic [4*PIX_W-1:0] i_RGB;
  logic               o_ready, o_valid, o_last;
  logic [PIX_W-1:0]   o_gray;
  logic               o_ready1, o_valid1, o_last1;
  logic [PIX_W-1:0]   o_gray1;

  gray_stream_pipe #(.PIX_W(PIX_W), .FRAME_PIXELS(FP)) dut (
    .clk(clk), .rst(rst), .i_mode(i_mode), .i_valid(i_valid), .o_ready(o_ready),
    .i_RGB(i_RGB), .o_valid(o_valid), .i_ready(i_ready), .o_gray(o_gray), .o_last(o_last)
  );

  gray_stream_pipe #(.PIX_W(PIX_W), .FRAME_PIXELS(1)) dut1 (
    .clk(clk), .rst(rst), .i_mode(i_mode), .i_valid(i_valid), .o_ready(o_ready1),
    .i_RGB(i_RGB), .o_valid(o_valid1), .i_ready(i_ready), .o_gray(o_gray1), .o_last(o_last1)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int exp_q[$];
  int hs_cyc[$];
  int out_cnt = 0;
  int cyc     = 0;
  logic             prev_stall = 1'b0;
  logic [PIX_W-1:0] prev_gray;
  logic             prev_last;

  function automatic int gray_ref(input logic [1:0] mode, input int r, input int g, input int b);
    int mx, mn;
    mx = r; mn = r;
    if (g > mx) mx = g;
    if (b > mx) mx = b;
    if (g < mn) mn = g;
    if (b < mn) mn = b;
    case (mode)
      2'd0:    return ((mx + mn) / 2) % 256;
      2'd1:    return ((77 * r + 150 * g + 29 * b) / 256) % 256;
      2'd2:    return (((r + g + b) * 171) / 512) % 256;
      default: return mx;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // One clock: sample at the falling edge, score, then return just after the rising edge.
  task automatic cycle();
    logic acc;
    @(negedge clk);
    acc = i_valid && (o_ready === 1'b1);
    check("o_ready", {31'd0, o_ready}, {31'd0, !(o_valid && !i_ready)});
    check("o_valid_fp1", {31'd0, o_valid1}, {31'd0, o_valid});
    if (prev_stall) begin
      check("stall_valid", {31'd0, o_valid}, 32'd1);
      check("stall_gray", {24'd0, o_gray}, {24'd0, prev_gray});
      check("stall_last", {31'd0, o_last}, {31'd0, prev_last});
    end
    if (o_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", exp_q.size(), 1);
      end else begin
        check("gray", {24'd0, o_gray}, exp_q[0]);
        check("last", {31'd0, o_last}, ((out_cnt % FP) == FP - 1) ? 32'd1 : 32'd0);
        check("gray_fp1", {24'd0, o_gray1}, exp_q[0]);
        check("last_fp1", {31'd0, o_last1}, 32'd1);
      end
    end
    prev_stall = o_valid && !i_ready;
    prev_gray  = o_gray;
    prev_last  = o_last;
    if (o_valid && i_ready && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      out_cnt++;
      hs_cyc.push_back(cyc);
    end
    if (acc)
      exp_q.push_back(gray_ref(i_mode, int'(i_RGB[4*PIX_W-1:3*PIX_W]),
                               int'(i_RGB[3*PIX_W-1:2*PIX_W]), int'(i_RGB[2*PIX_W-1:PIX_W])));
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int k = 0; k < 20 && (exp_q.size() > 0 || o_valid); k++) cycle();
    check("drain_empty", exp_q.size(), 0);
    check("drain_idle", {31'd0, o_valid}, 32'd0);
  endtask

  task automatic do_reset();
    i_valid = 1'b0;
    rst     = 1'b1;
    #1;
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_gray", {24'd0, o_gray}, 32'd0);
    check("rst_last", {31'd0, o_last}, 32'd0);
    check("rst_ready", {31'd0, o_ready}, 32'd1);
    exp_q.delete();
    out_cnt    = 0;
    prev_stall = 1'b0;
    @(posedge clk);
    #1;
    check("rst_valid_next", {31'd0, o_valid}, 32'd0);
    rst = 1'b0;
  endtask

  // Single pixel into an empty pipe: checks latency and a hand-computed result.
  task automatic run_one(input string tag, input logic [1:0] mode, input logic [7:0] r,
                         input logic [7:0] g, input logic [7:0] b, input int exp);
    int lat;
    i_mode  = mode;
    i_RGB   = {r, g, b, 8'h5a};
    i_valid = 1'b1;
    i_ready = 1'b1;
    cycle();
    i_valid = 1'b0;
    lat = 1;
    while (o_valid !== 1'b1 && lat < 10) begin
      cycle();
      lat++;
    end
    check({tag, "_latency"}, lat, 3);
    check({tag, "_gray"}, {24'd0, o_gray}, exp);
    cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [1:0] m;
    rst     = 1'b1;
    i_mode  = 2'd0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_RGB   = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // T1 / T2: hand-computed values and fixed latency.
    run_one("t1_light", 2'd0, 8'd200, 8'd100, 8'd50, 125);
    run_one("t2_lum",   2'd1, 8'd200, 8'd100, 8'd50, 124);
    run_one("t2_avg",   2'd2, 8'd200, 8'd100, 8'd50, 116);
    run_one("t2_value", 2'd3, 8'd200, 8'd100, 8'd50, 200);
    for (int md = 0; md < 4; md++) begin
      run_one("t2_white", md[1:0], 8'd255, 8'd255, 8'd255, 255);
      run_one("t2_black", md[1:0], 8'd0, 8'd0, 8'd0, 0);
    end

    // T3: ten back-to-back pixels, mode changes on every pixel.
    hs_cyc.delete();
    m = 2'd0;
    i_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      i_mode  = m;
      i_RGB   = $urandom;
      i_valid = 1'b1;
      cycle();
      m = 2'((int'(m) + 1 + $urandom_range(0, 2)) % 4);
    end
    drain();
    check("t3_outputs", hs_cyc.size(), 10);
    if (hs_cyc.size() == 10) check("t3_consecutive", hs_cyc[9] - hs_cyc[0], 9);

    // T4: full pipe, five stalled cycles with the source still offering pixels.
    for (int i = 0; i < 3; i++) begin
      i_mode = 2'($urandom); i_RGB = $urandom; i_valid = 1'b1; cycle();
    end
    i_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      i_mode = 2'($urandom); i_RGB = $urandom; i_valid = 1'b1; cycle();
    end
    i_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_mode = 2'($urandom); i_RGB = $urandom; i_valid = 1'b1; cycle();
    end
    drain();

    // T5: frame flags from a known frame start, then random flow control.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      i_mode = 2'($urandom); i_RGB = $urandom; i_valid = 1'b1; i_ready = 1'b1; cycle();
    end
    drain();
    check("t5_out_count", out_cnt, 9);
    for (int i = 0; i < 60; i++) begin
      i_mode  = 2'($urandom);
      i_RGB   = $urandom;
      i_valid = 1'($urandom);
      i_ready = 1'($urandom);
      cycle();
    end
    drain();

    // T6: reset with pixels in flight, then a fresh frame.
    for (int i = 0; i < 3; i++) begin
      i_mode = 2'($urandom); i_RGB = $urandom; i_valid = 1'b1; i_ready = 1'b1; cycle();
    end
    do_reset();
    for (int i = 0; i < 5; i++) begin
      i_mode = 2'($urandom); i_RGB = $urandom; i_valid = 1'b1; i_ready = 1'b1; cycle();
    end
    drain();
    check("t6_out_count", out_cnt, 5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
